// File: rtl/key_schedule_seq.sv
// Sequential AES key-expansion engine: streams w[0..Nw-1] for 128/192/256-bit keys,
// one 32-bit word per accepted cycle over a valid/ready port.
module key_schedule_seq #(
  parameter bit ENABLE_192 = 1'b1,
  parameter bit ENABLE_256 = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  input  logic         abort,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_word,
  output logic [5:0]   out_index,
  output logic [3:0]   out_round,
  output logic         out_last,
  output logic         done,
  output logic         err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state_q, state_d;
  logic [5:0]   idx_q, idx_d;
  logic [2:0]   kcnt_q, kcnt_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [1:0]   len_q, len_d;
  logic [255:0] key_q, key_d;
  logic [31:0]  word_q, word_d;
  logic [31:0]  hist_q [8];
  logic [31:0]  hist_d [8];
  logic         done_q, done_d, err_q, err_d;

  logic [2:0]   nk_m1, nk_m2;
  logic [5:0]   nw_m1, n;
  logic [2:0]   kn;
  logic [3:0]   rn;
  logic [31:0]  kw [8];
  logic [31:0]  temp, nxt_word;
  logic         len_ok, is_last;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inversion through the GF(2^4) subfield: the norm x^17 lies in GF(16), whose
  // inverse is n^14, so x^-1 = x^16 * (x^17)^14 (and 0 maps to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x4, x8, x16, nrm, n2, n4, n8;
    x2  = gf_mul(x, x);
    x4  = gf_mul(x2, x2);
    x8  = gf_mul(x4, x4);
    x16 = gf_mul(x8, x8);
    nrm = gf_mul(x16, x);
    n2  = gf_mul(nrm, nrm);
    n4  = gf_mul(n2, n2);
    n8  = gf_mul(n4, n4);
    return gf_mul(x16, gf_mul(gf_mul(n8, n4), n2));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    case (len_q)
      2'b01:   begin nk_m1 = 3'd5; nk_m2 = 3'd4; nw_m1 = 6'd51; end
      2'b10:   begin nk_m1 = 3'd7; nk_m2 = 3'd6; nw_m1 = 6'd59; end
      default: begin nk_m1 = 3'd3; nk_m2 = 3'd2; nw_m1 = 6'd43; end
    endcase
  end

  always_comb begin
    case (key_len)
      2'b00:   len_ok = 1'b1;
      2'b01:   len_ok = ENABLE_192;
      2'b10:   len_ok = ENABLE_256;
      default: len_ok = 1'b0;
    endcase
  end

  always_comb begin
    for (int j = 0; j < 8; j++) kw[j] = key_q[255-32*j -: 32];
  end

  assign is_last = (idx_q == nw_m1);

  // Next word w[idx+1]; hist_q[j] holds w[idx-1-j], so w[idx+1-Nk] sits at Nk-2.
  always_comb begin
    n    = idx_q + 6'd1;
    kn   = (kcnt_q == nk_m1) ? 3'd0 : kcnt_q + 3'd1;
    rn   = (kn == 3'd0) ? rnd_q + 4'd1 : rnd_q;
    temp = word_q;
    if (kn == 3'd0)
      temp = sub_word(rot_word(word_q)) ^ {rcon(rn), 24'h0};
    else if (nk_m1 == 3'd7 && kn == 3'd4)
      temp = sub_word(word_q);
    if (idx_q < {3'b000, nk_m1})
      nxt_word = kw[n[2:0]];
    else
      nxt_word = hist_q[nk_m2] ^ temp;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    kcnt_d  = kcnt_q;
    rnd_d   = rnd_q;
    len_d   = len_q;
    key_d   = key_q;
    word_d  = word_q;
    hist_d  = hist_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            state_d = RUN;
            key_d   = key;
            len_d   = key_len;
            idx_d   = '0;
            kcnt_d  = '0;
            rnd_d   = '0;
            word_d  = key[255:224];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        // abort takes priority, so a word presented alongside it is not delivered
        if (abort) begin
          state_d = IDLE;
        end else if (out_ready) begin
          hist_d[0] = word_q;
          for (int j = 1; j < 8; j++) hist_d[j] = hist_q[j-1];
          if (is_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d  = n;
            kcnt_d = kn;
            rnd_d  = rn;
            word_d = nxt_word;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      kcnt_q  <= '0;
      rnd_q   <= '0;
      len_q   <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int j = 0; j < 8; j++) hist_q[j] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      kcnt_q  <= kcnt_d;
      rnd_q   <= rnd_d;
      len_q   <= len_d;
      word_q  <= word_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hist_q  <= hist_d;
    end
  end

  always_ff @(posedge clk) begin
    key_q <= key_d;
  end

  assign busy      = (state_q == RUN);
  assign out_valid = busy;
  assign out_word  = busy ? word_q : '0;
  assign out_index = busy ? idx_q : '0;
  assign out_round = busy ? idx_q[5:2] : '0;
  assign out_last  = busy & is_last;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_key_schedule_seq.sv
// Directed bench for key_schedule_seq: an independent key-expansion model fills a
// scoreboard that is drained as the DUT hands over words.
module tb_key_schedule_seq;

  logic         clk = 1'b0;
  logic         rst, start, abort, out_ready;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic         busy, out_valid, out_last, done, err;
  logic [31:0]  out_word;
  logic [5:0]   out_index;
  logic [3:0]   out_round;

  logic         start2;
  logic [1:0]   key_len2;
  logic         busy2, valid2, last2, done2, err2;
  logic [31:0]  word2;
  logic [5:0]   index2;
  logic [3:0]   round2;

  key_schedule_seq dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key(key), .abort(abort),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_index(out_index), .out_round(out_round), .out_last(out_last), .done(done), .err(err)
  );

  key_schedule_seq #(.ENABLE_192(1'b1), .ENABLE_256(1'b0)) dut_n256 (
    .clk(clk), .rst(rst), .start(start2), .key_len(key_len2), .key(key), .abort(1'b0),
    .busy(busy2), .out_valid(valid2), .out_ready(1'b1), .out_word(word2),
    .out_index(index2), .out_round(round2), .out_last(last2), .done(done2), .err(err2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [5:0]  idx;
    logic [3:0]  rnd;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          total, passed;
  logic [31:0] exp_w [60];
  logic [31:0] got_w [60];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Polynomial product followed by long division by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) if (b[k]) p = p ^ (15'(a) << k);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'h11b << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv, s, c;
    inv = 8'h00;
    c   = 8'h63;
    for (int y = 1; y < 256; y++) if (m_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  function automatic logic [31:0] m_sub(input logic [31:0] w);
    return {m_sbox(w[31:24]), m_sbox(w[23:16]), m_sbox(w[15:8]), m_sbox(w[7:0])};
  endfunction

  task automatic m_expand(input logic [255:0] k, input logic [1:0] kl, output int nw);
    int nk;
    logic [31:0] t;
    logic [7:0] rc;
    nk = (kl == 2'b01) ? 6 : (kl == 2'b10) ? 8 : 4;
    nw = nk * 4 + 28;
    rc = 8'h01;
    for (int i = 0; i < nw; i++) begin
      if (i < nk) begin
        exp_w[i] = k[255-32*i -: 32];
      end else begin
        t = exp_w[i-1];
        if (i % nk == 0) begin
          t  = m_sub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = m_mul(rc, 8'h02);
        end else if (nk == 8 && i % nk == 4) begin
          t = m_sub(t);
        end
        exp_w[i] = exp_w[i-nk] ^ t;
      end
    end
  endtask

  task automatic run_key(input logic [255:0] k, input logic [1:0] kl,
                         input int rdy_pct, input int abort_at);
    int nw, cyc, done_cyc;
    bit stalled, done_seen, aborted;
    logic [31:0] pw;
    logic [5:0] pidx;
    exp_t e;
    m_expand(k, kl, nw);
    sb.delete();
    for (int i = 0; i < 60; i++) got_w[i] = '0;
    for (int i = 0; i < nw; i++) sb.push_back('{exp_w[i], 6'(i), 4'(i / 4), (i == nw - 1)});
    key = k; key_len = kl; start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0; key = ~k; key_len = 2'b11;
    check("start_busy", busy, 1);
    check("done_clr", done, 0);
    cyc = 0; stalled = 0; done_seen = 0; aborted = 0; done_cyc = -1;
    pw = '0; pidx = '0;
    while (cyc < 600 && !done_seen && !aborted) begin
      if (done) begin
        done_seen = 1; done_cyc = cyc;
        check("done_idle", {30'b0, busy, out_valid}, 0);
      end else begin
        if (stalled) begin
          check("stall_word", out_word, pw);
          check("stall_idx", out_index, pidx);
        end
        start = (cyc == 3);
        out_ready = ($urandom_range(99) < rdy_pct);
        if (out_valid && out_index == abort_at) begin
          abort = 1'b1; out_ready = 1'b1;
          step();
          abort = 1'b0; aborted = 1;
          check("abort_busy", busy, 0);
          check("abort_valid", out_valid, 0);
          check("abort_done", done, 0);
          step();
          check("abort_nodone", done, 0);
        end else begin
          if (out_valid && out_ready) begin
            check("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
              e = sb.pop_front();
              check("word", out_word, e.w);
              check("index", out_index, e.idx);
              check("round", out_round, e.rnd);
              check("last", out_last, e.last);
              got_w[out_index] = out_word;
            end
          end
          stalled = out_valid && !out_ready;
          pw = out_word; pidx = out_index;
          step();
          cyc++;
        end
      end
    end
    start = 1'b0; out_ready = 1'b1;
    if (abort_at < 0) begin
      check("done_seen", done_seen, 1);
      check("sb_empty", sb.size(), 0);
      if (rdy_pct == 100) check("done_lat", done_cyc, nw);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    total = 0; passed = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    key = '0; key_len = 2'b00; start2 = 1'b0; key_len2 = 2'b00;
    #12;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_word", out_word, 0);
    check("rst_index", out_index, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    run_key(K128, 2'b00, 100, -1);
    check("w128_4", got_w[4], 32'ha0fafe17);
    check("w128_43", got_w[43], 32'hb6630ca6);

    run_key(K192, 2'b01, 100, -1);
    check("w192_6", got_w[6], 32'hfe0c91f7);
    check("w192_51", got_w[51], 32'h01002202);

    run_key(K256, 2'b10, 100, -1);
    check("w256_8", got_w[8], 32'h9ba35411);
    check("w256_12", got_w[12], 32'ha8b09c1a);
    check("w256_59", got_w[59], 32'h706c631e);

    run_key(K256, 2'b10, 50, -1);
    check("bp_w256_12", got_w[12], 32'ha8b09c1a);
    check("bp_w256_59", got_w[59], 32'h706c631e);

    step();
    start = 1'b1; key_len = 2'b11;
    step();
    start = 1'b0;
    check("err11_pulse", err, 1);
    check("err11_busy", busy, 0);
    check("err11_valid", out_valid, 0);
    step();
    check("err11_clr", err, 0);
    check("err11_busy2", busy, 0);

    start2 = 1'b1; key_len2 = 2'b10;
    step();
    start2 = 1'b0;
    check("err256_pulse", err2, 1);
    check("err256_busy", busy2, 0);
    check("err256_valid", valid2, 0);
    step();
    check("err256_clr", err2, 0);
    check("err256_outs", {word2, index2, round2, last2, done2}, 0);

    run_key(K128, 2'b00, 100, 20);
    run_key(K128, 2'b00, 100, -1);
    check("restart_w0", got_w[0], 32'h2b7e1516);

    key = K128; key_len = 2'b00; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", out_valid, 0);
    check("arst_word", out_word, 0);
    check("arst_index", out_index, 0);
    check("arst_round", out_round, 0);
    check("arst_last", out_last, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post_rst_done", done, 0);
    check("post_rst_err", err, 0);
    check("post_rst_busy", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
